// File: rtl/ram_ahbl_pkg.sv
// Shared encodings, FSM state type and response codes for the AHB-Lite to DFFRAM bridge.
// State set depends on RAM_AHBL_BRIDGE_ERR_EN (adds the ERROR response states).
package ram_ahbl_pkg;

    localparam int unsigned RAM_AW = 13;
    localparam int unsigned DW     = 32;
    localparam int unsigned MASK_W = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WDATA = 3'd1,
        ST_RDATA = 3'd2,
`ifdef RAM_AHBL_BRIDGE_ERR_EN
        ST_STALL = 3'd3,
        ST_ERR1  = 3'd4,
        ST_ERR2  = 3'd5
`else
        ST_STALL = 3'd3
`endif
    } state_e;

endpackage

// File: rtl/ram_ahbl_bridge_if.sv
// AHB-Lite slave bus plus DFFRAM macro port, bundled for the bridge.
interface ram_ahbl_bridge_if
    import ram_ahbl_pkg::*;
#(
    parameter int unsigned AW = RAM_AW
) ();

    logic              HSEL;
    logic [31:0]       HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic              HREADY;
    logic [DW-1:0]     HWDATA;
    logic [DW-1:0]     HRDATA;
    logic              HREADYOUT;
    logic              HRESP;

    logic              RAM_EN;
    logic [MASK_W-1:0] RAM_WE;
    logic [AW-1:0]     RAM_A;
    logic [DW-1:0]     RAM_Di;
    logic [DW-1:0]     RAM_Do;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA, RAM_Do,
        output HRDATA, HREADYOUT, HRESP, RAM_EN, RAM_WE, RAM_A, RAM_Di
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA, RAM_Do,
        input  HRDATA, HREADYOUT, HRESP, RAM_EN, RAM_WE, RAM_A, RAM_Di
    );

endinterface

// File: rtl/ram_ahbl_bytemask.sv
// Byte-lane mask from HSIZE and the low address bits, plus a flag for
// unsupported sizes and misaligned half/word accesses.
module ram_ahbl_bytemask
    import ram_ahbl_pkg::*;
(
    input  logic [2:0]        hsize_i,
    input  logic [1:0]        addr_lo_i,
    output logic [MASK_W-1:0] mask_o,
    output logic              misalign_o
);

    always_comb begin
        mask_o     = 4'b1111;
        misalign_o = 1'b0;
        case (hsize_i)
            HSIZE_BYTE: mask_o = 4'b0001 << addr_lo_i;
            HSIZE_HALF: begin
                mask_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                misalign_o = addr_lo_i[0];
            end
            HSIZE_WORD: misalign_o = (addr_lo_i != 2'b00);
            // Oversized transfers fall back to a full-word lane mask
            default:    misalign_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ram_ahbl_bridge.sv
// AHB-Lite slave bridge onto a single-port DFFRAM: zero-wait reads/writes, one stall on read-after-write.
// Define RAM_AHBL_BRIDGE_ERR_EN to answer unsupported/misaligned transfers with a two-cycle ERROR.
module ram_ahbl_bridge
    import ram_ahbl_pkg::*;
#(
    parameter int unsigned AW = RAM_AW
) (
    input  logic             CLK,
    input  logic             RST,
    ram_ahbl_bridge_if.slave bus
);

    state_e            state_q, state_d;
    logic [AW-1:0]     waddr_q, waddr_d;
    logic [AW-1:0]     raddr_q, raddr_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic              hready_q, hready_d;

    logic [AW-1:0]     haddr_word;
    logic [MASK_W-1:0] size_mask;
    logic              misalign;
    logic              accept;
    logic              req_ok;
    logic              acc_wr;
    logic              acc_rd;
    logic              busy;

    logic              ram_en_c;
    logic [MASK_W-1:0] ram_we_c;
    logic [AW-1:0]     ram_a_c;

    ram_ahbl_bytemask u_bytemask (
        .hsize_i    (bus.HSIZE),
        .addr_lo_i  (bus.HADDR[1:0]),
        .mask_o     (size_mask),
        .misalign_o (misalign)
    );

    assign haddr_word = bus.HADDR[AW+1:2];
    // Reset also blocks new strobes so nothing reaches the macro while RST is high
    assign accept     = bus.HSEL & bus.HTRANS[1] & bus.HREADY & ~RST;

    logic unused_bits;
    assign unused_bits = ^{bus.HTRANS[0], bus.HADDR[31:AW+2]};

`ifdef RAM_AHBL_BRIDGE_ERR_EN
    logic acc_err;
    logic hresp_q, hresp_d;
    assign acc_err = accept & misalign;
    assign req_ok  = accept & ~misalign;
    assign busy    = (state_q == ST_STALL) || (state_q == ST_ERR1);
`else
    logic unused_misalign;
    assign unused_misalign = misalign;
    assign req_ok  = accept;
    assign busy    = (state_q == ST_STALL);
`endif

    assign acc_wr = req_ok & bus.HWRITE;
    assign acc_rd = req_ok & ~bus.HWRITE;

    // Next state, latched addresses and RAM strobes
    always_comb begin
        state_d  = ST_IDLE;
        waddr_d  = waddr_q;
        wmask_d  = wmask_q;
        raddr_d  = raddr_q;
        ram_en_c = 1'b0;
        ram_we_c = '0;
        ram_a_c  = haddr_word;

        case (state_q)
            ST_WDATA: begin
                ram_en_c = 1'b1;
                ram_we_c = wmask_q;
                ram_a_c  = waddr_q;
            end
            ST_STALL: begin
                ram_en_c = 1'b1;
                ram_a_c  = raddr_q;
                state_d  = ST_RDATA;
            end
`ifdef RAM_AHBL_BRIDGE_ERR_EN
            ST_ERR1:  state_d = ST_ERR2;
`endif
            default: ;
        endcase

        if (!busy) begin
            if (acc_wr) begin
                state_d = ST_WDATA;
                waddr_d = haddr_word;
                wmask_d = size_mask;
            end else if (acc_rd) begin
                if (state_q == ST_WDATA) begin
                    // The pending write owns the macro this cycle; replay the read next cycle
                    state_d = ST_STALL;
                    raddr_d = haddr_word;
                end else begin
                    ram_en_c = 1'b1;
                    ram_we_c = '0;
                    ram_a_c  = haddr_word;
                    state_d  = ST_RDATA;
                end
            end
`ifdef RAM_AHBL_BRIDGE_ERR_EN
            if (acc_err) begin
                state_d = ST_ERR1;
            end
`endif
        end
    end

`ifdef RAM_AHBL_BRIDGE_ERR_EN
    assign hready_d = (state_d != ST_STALL) && (state_d != ST_ERR1);
    assign hresp_d  = (state_d == ST_ERR1) || (state_d == ST_ERR2);
`else
    assign hready_d = (state_d != ST_STALL);
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            waddr_q  <= '0;
            raddr_q  <= '0;
            wmask_q  <= '0;
            hready_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            waddr_q  <= waddr_d;
            raddr_q  <= raddr_d;
            wmask_q  <= wmask_d;
            hready_q <= hready_d;
        end
    end

`ifdef RAM_AHBL_BRIDGE_ERR_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hresp_q <= RESP_OKAY;
        end else begin
            hresp_q <= hresp_d;
        end
    end
    assign bus.HRESP = hresp_q;
`else
    assign bus.HRESP = RESP_OKAY;
`endif

    assign bus.HREADYOUT = hready_q;
    assign bus.HRDATA    = bus.RAM_Do;
    assign bus.RAM_EN    = ram_en_c;
    assign bus.RAM_WE    = ram_we_c;
    assign bus.RAM_A     = ram_a_c;
    assign bus.RAM_Di    = bus.HWDATA;

endmodule

// File: doc/ram_ahbl_bridge.md
# ram_ahbl_bridge

AHB-Lite slave bridge sitting directly upstream of the banked 32-bit DFFRAM macros (8K×32 configuration by default). Converts AHB-Lite address/data-phase transfers into single-port RAM strobes (`EN`, byte `WE`, `A`, `Di`) and returns the macro's registered `Do` as `HRDATA`. Zero-wait reads and writes; one wait state only when a read address phase collides with a write data phase.

## Interface
- `AW`, 13, RAM word-address width; `HADDR[AW+1:2]` selects the word.
- `CLK`  in  1  system clock; RAM macro clocked by the same net.
- `RST`  in  1  asynchronous, active-high reset.
- `HSEL`  in  1  slave select.
- `HADDR`  in  32  byte address.
- `HTRANS`  in  2  transfer type; only bit 1 (NONSEQ/SEQ) is decoded.
- `HWRITE`  in  1  1 = write.
- `HSIZE`  in  3  0 = byte, 1 = half, 2 = word.
- `HREADY`  in  1  bus-wide ready.
- `HWDATA`  in  32  write data, data phase.
- `HRDATA`  out  32  read data.
- `HREADYOUT`  out  1  slave ready.
- `HRESP`  out  1  0 = OKAY, 1 = ERROR.
- `RAM_EN`  out  1  macro enable.
- `RAM_WE`  out  4  byte write enables.
- `RAM_A`  out  AW  word address.
- `RAM_Di`  out  32  write data.
- `RAM_Do`  in  32  macro read data, valid the cycle after an enabled read edge.

## Operation
- Transfer accepted when `HSEL & HTRANS[1] & HREADY`.
- Byte mask:
  - `HSIZE=0`: `4'b0001 << HADDR[1:0]`.
  - `HSIZE=1`: `HADDR[1] ? 4'b1100 : 4'b0011`.
  - `HSIZE=2`: `4'b1111`.
- States: `IDLE`, `WDATA`, `RDATA`, `STALL`, `ERR1`, `ERR2`.
- Read accepted in `IDLE`/`RDATA`:
  - Same cycle, combinationally: `RAM_EN=1`, `RAM_WE=0`, `RAM_A=HADDR[AW+1:2]`.
  - Next state `RDATA`: `HRDATA=RAM_Do`, `HREADYOUT=1`.
- Write accepted: word address and byte mask are registered; next state `WDATA`.
  - In `WDATA`: `RAM_EN=1`, `RAM_WE=mask`, `RAM_A=registered address`, `RAM_Di=HWDATA`, `HREADYOUT=1`.
- Collision (read accepted while in `WDATA`):
  - The write owns the RAM and the read address is latched.
  - Next state `STALL`: `HREADYOUT=0`; RAM is read at the latched address.
  - Then `RDATA`.
  - Read-after-write to the same address returns the new data.
- Write accepted while in `WDATA`: no collision, back-to-back `WDATA`.
- No transfer accepted: next state `IDLE`, `RAM_EN=0`, `RAM_WE=0`.
- `HRDATA` is a pass-through of `RAM_Do` in every state; its value is only meaningful in `RDATA`.
- Reset values: state `IDLE`, `HREADYOUT=1`, `HRESP=0`, `RAM_EN=0`, `RAM_WE=0`, latched address/mask = 0.
- Reset mid-`STALL` or mid-`WDATA`: the pending access is dropped and no RAM strobe is issued after reset.

## Timing
- Read latency: address phase in cycle N, `RAM_Do`/`HRDATA` valid in cycle N+1; 2 cycles with collision.
- Write: RAM write edge is the clock edge ending the data phase.
- A new read issued during `RDATA` is legal: `RAM_Do` changes only after the edge that ends `RDATA`.
- `RAM_EN` is never asserted without a transfer (power).
- ERROR response takes two cycles:
  - `ERR1`: `HREADYOUT=0`, `HRESP=1`.
  - `ERR2`: `HREADYOUT=1`, `HRESP=1`.
  - No RAM strobe in either cycle.

## Configuration
- `RAM_AHBL_BRIDGE_ERR_EN` defined:
  - These transfers get the two-cycle ERROR response: `HSIZE>2`, half-word with `HADDR[0]=1`, word with `HADDR[1:0]!=0`.
  - An erroring transfer accepted during `WDATA` still lets the write complete first.
- Not defined:
  - No `ERR1`/`ERR2` states; `HRESP` is tied to 0.
  - `HSIZE>2` is treated as a word access.
  - Misaligned low address bits are ignored for the mask; the `HSIZE=0`/`1` rules above apply unchanged.

## Structure
- Package `ram_ahbl_pkg`: `HTRANS`/`HSIZE` encodings, state enum, `RESP_OKAY`/`RESP_ERROR` constants.
- One combinational sub-module, `ram_ahbl_bytemask`: `HSIZE` + `HADDR[1:0]` → 4-bit mask plus misaligned flag.

## Test plan
- Reset, then idle bus → `HREADYOUT=1`, `HRESP=0`, `RAM_EN=0`, `RAM_WE=0`.
- Word write `0xDEADBEEF` @ `0x0000_0010`, then read @ `0x10` → `RAM_WE=4'b1111`, `RAM_A=4`; read returns `0xDEADBEEF` with zero wait states.
- Byte write `0xAA` @ `0x13` over `0x11223344`, then read → `RAM_WE=4'b1000`; read returns `0xAA223344`.
- Back-to-back write `0x5` @ `0x20` followed immediately by read @ `0x20` → one cycle `HREADYOUT=0`, then `HRDATA=0x5`.
- Assert `RST` during `STALL` → `HREADYOUT=1` and `RAM_EN=0` immediately; no read strobe afterwards.
- With `RAM_AHBL_BRIDGE_ERR_EN`, word read @ `0x2` → `ERR1`/`ERR2` sequence and no `RAM_EN`. Without the macro, same access → `RAM_A=0`, OKAY response.
